dp: RTL

- Booth multiplier datapath, directly downstream of the Booth control unit; consumes its 8-bit control word `c` and returns status `q0`, `qm` and `count`.
- Holds registers A (accumulator), Q (multiplier), Q-1, M (multiplicand) and the iteration counter.
- Operands enter on `inbus`; the 2*WIDTH-bit signed product leaves on `outbus`, high half then low half.

---
 rtl/dp.sv | 97 +++++++++
 1 files changed

// File: rtl/dp.sv
// Booth multiplier datapath: A/Q/Q-1/M registers, iteration counter and a
// registered result port, all driven by the control unit's 8-bit control word.
module dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       c,
  input  logic [WIDTH-1:0] inbus,
  output logic             q0,
  output logic             qm,
  output logic             count,
  output logic [WIDTH-1:0] outbus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam int B_LOAD_M = 0;
  localparam int B_LOAD_Q = 1;
  localparam int B_ARITH  = 2;
  localparam int B_SUB    = 3;
  localparam int B_SHIFT  = 4;
  localparam int B_INC    = 5;
  localparam int B_OUT_A  = 6;
  localparam int B_OUT_Q  = 7;

  // A carries one extra sign bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm_q, qm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH:0]   m_ext;

  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    qm_d  = qm_q;
    cnt_d = cnt_q;
    out_d = out_q;

    // Register group: only the highest-priority set bit acts.
    if (c[B_LOAD_M]) begin
      m_d  = inbus;
      a_d  = '0;
      qm_d = 1'b0;
    end else if (c[B_LOAD_Q]) begin
      q_d = inbus;
    end else if (c[B_ARITH]) begin
      a_d = c[B_SUB] ? (a_q - m_ext) : (a_q + m_ext);
    end else if (c[B_SHIFT]) begin
      {a_d, q_d, qm_d} = {a_q[WIDTH], a_q, q_q};
    end

    if (c[B_LOAD_M]) begin
      cnt_d = '0;
    end else if (c[B_INC]) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Output load samples the pre-update A/Q.
    if (c[B_OUT_A]) begin
      out_d = a_q[WIDTH-1:0];
    end else if (c[B_OUT_Q]) begin
      out_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm_q  <= qm_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign q0     = q_q[0];
  assign qm     = qm_q;
  assign count  = (cnt_q == CNT_LAST);
  assign outbus = out_q;

endmodule
